block_config_latches_unit: RTL and testbench
============================================

# block_config_latches_unit

Configuration memory and read mux for one LUT-style logic element. It holds a truth table of 2^ADDR_BITS bits, written from the configuration bus on the configuration clock while the block's enable is asserted. Its addressed bit is driven combinationally to `out`. The parent LUT instantiates it with the LUT inputs on `addr` and the full-width configuration word on `config_in`.

## Interface
Parameters:
- `ADDR_BITS`, default 4: address width (LUT input count).
- `MEM_SIZE`, default 2**ADDR_BITS: number of stored configuration bits. Must equal 2**ADDR_BITS.
- `CONFIG_WIDTH`, default MEM_SIZE: bits loaded per enabled clock. MEM_SIZE must be an integer multiple of CONFIG_WIDTH.

Ports:
- `cclk`, input, 1: configuration clock. One clock domain, rising edge.
- `cresetn`, input, 1: reset. Synchronous, active-low.
- `cen`, input, 1: configuration enable. A load occurs on a rising `cclk` edge while `cen`=1.
- `config_in`, input, CONFIG_WIDTH: configuration data.
- `addr`, input, ADDR_BITS: truth-table index.
- `out`, output, 1: stored bit `mem[addr]`.

## Operation
- Internal state is `mem[MEM_SIZE-1:0]`. It is clocked by `cclk` only.
- Reset: on a rising `cclk` edge with `cresetn`=0, `mem` becomes all zeros.
  - Reset has priority over `cen`.
  - Reset behaves the same in the middle of a multi-chunk load: any partial load is discarded.
- Load: on a rising `cclk` edge with `cresetn`=1 and `cen`=1:
  - If CONFIG_WIDTH == MEM_SIZE: `mem <= config_in`, a single-cycle full replace.
  - Otherwise: shift in one chunk, `mem <= {config_in, mem[MEM_SIZE-1:CONFIG_WIDTH]}`. After MEM_SIZE/CONFIG_WIDTH enabled edges, the first chunk sits in `mem[CONFIG_WIDTH-1:0]` and the last chunk sits in the top bits.
  - There is no chunk counter and no completion flag. Extra enabled edges keep shifting.
- Hold: with `cresetn`=1 and `cen`=0, `mem` is unchanged regardless of `config_in` activity.
- Read: `out = mem[addr]`, combinational.
  - Every `addr` value is in range because MEM_SIZE = 2**ADDR_BITS.
  - `addr` never affects `mem`.
- Before the first reset, `mem` (and therefore `out`) is undefined. Users must reset or fully load before relying on `out`.

## Timing
- Read latency is zero cycles: `out` follows `addr` combinationally.
- Write latency is one edge: a new `mem` value is visible on `out` immediately after the rising `cclk` edge that loads it.
- After a reset edge, `out` = 0 for all `addr`. It stays 0 until the next enabled load.
- `cen` and `config_in` are sampled only at rising `cclk`. Glitches between edges have no effect.
- A `cen` low-high-low pulse that spans exactly one rising edge performs exactly one load (one chunk).
- Simultaneous `cresetn`=0 and `cen`=1 on the same edge results in `mem`=0.

## Test plan
1. Reset and read. With ADDR_BITS=4, hold `cresetn`=0 for one `cclk` edge, then release. Sweep `addr` 0..15: `out`=0 for every address.
2. Full load and read. Set `cen`=1 and `config_in`=16'hA5C3 for one edge, then set `cen`=0. Expected outputs:
   - `addr`=0 gives 1; `addr`=2 gives 0.
   - `addr`=6 gives 1; `addr`=8 gives 1.
   - `addr`=15 gives 1; `addr`=14 gives 0.
   - The full sweep reproduces 16'hA5C3 bit-for-bit.
3. Hold. After scenario 2, keep `cen`=0, drive `config_in`=16'hFFFF and toggle `cclk` 5 times: the sweep still reproduces 16'hA5C3.
4. Reset priority. On one edge set `cen`=1, `config_in`=16'hFFFF and `cresetn`=0: afterwards all addresses read 0.
5. Chunked load. With CONFIG_WIDTH=4, apply four enabled edges with `config_in` = 4'h3, 4'hC, 4'h5, 4'hA: `mem` = 16'hA5C3. Asserting reset after only two chunks results in `mem`=0.
6. Combinational read. With `mem`=16'hA5C3 and `cclk` stopped, change `addr` from 0 to 2: `out` goes from 1 to 0 with no clock edge.

Source files
------------

// File: rtl/block_config_latches_unit.sv
// Truth-table storage and read mux for one LUT element.
// The table is filled from the configuration bus, either whole or in chunks shifted in from the top.
module block_config_latches_unit #(
  parameter int ADDR_BITS    = 4,
  parameter int MEM_SIZE     = 2**ADDR_BITS,
  parameter int CONFIG_WIDTH = MEM_SIZE
) (
  input  logic                    cclk,
  input  logic                    cresetn,
  input  logic                    cen,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  input  logic [ADDR_BITS-1:0]    addr,
  output logic                    out
);

  logic [MEM_SIZE-1:0] r_mem;

  generate
    if (CONFIG_WIDTH == MEM_SIZE) begin : g_full
      always_ff @(posedge cclk) begin
        if (!cresetn)
          r_mem <= '0;
        else if (cen)
          r_mem <= config_in;
      end
    end else begin : g_shift
      // Newest chunk enters at the top, so the first chunk of a complete load ends up in the low bits.
      always_ff @(posedge cclk) begin
        if (!cresetn)
          r_mem <= '0;
        else if (cen)
          r_mem <= {config_in, r_mem[MEM_SIZE-1:CONFIG_WIDTH]};
      end
    end
  endgenerate

  assign out = r_mem[addr];

endmodule

// File: tb/tb_block_config_latches_unit.sv
// Scoreboard bench for block_config_latches_unit: one full-width instance and one 4-bit chunked instance.
module tb_block_config_latches_unit;

  logic        cclk = 1'b0;
  logic        rstnFull, cenFull, rstnChunk, cenChunk;
  logic [15:0] cfgFull;
  logic [3:0]  cfgChunk;
  logic [3:0]  addr;
  logic        outFull, outChunk;

  always #50 cclk = ~cclk;

  block_config_latches_unit #(.ADDR_BITS(4)) dutFull (
    .cclk(cclk), .cresetn(rstnFull), .cen(cenFull),
    .config_in(cfgFull), .addr(addr), .out(outFull)
  );

  block_config_latches_unit #(.ADDR_BITS(4), .CONFIG_WIDTH(4)) dutChunk (
    .cclk(cclk), .cresetn(rstnChunk), .cen(cenChunk),
    .config_in(cfgChunk), .addr(addr), .out(outChunk)
  );

  typedef struct {
    bit       chunked;
    int       a;
    logic     exp;
    string    tag;
  } expT;

  expT  sbQ[$];
  event sampleEv;
  int   checks = 0;
  int   failures = 0;

  // Reference model: the stored truth tables as plain 16-bit values.
  logic [15:0] modelFull;
  logic [15:0] modelChunk;

  // Monitor: pops every expectation posted for the current sample point and compares.
  initial begin
    expT  e;
    logic act;
    forever begin
      @(sampleEv);
      while (sbQ.size() > 0) begin
        e   = sbQ.pop_front();
        act = e.chunked ? outChunk : outFull;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("[TB] FAIL %s dut=%s addr=%0d got=%b expected=%b",
                   e.tag, e.chunked ? "chunk" : "full", e.a, act, e.exp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rf, input logic cf, input logic [15:0] df,
                               input logic rc, input logic cc, input logic [3:0] dc);
    @(negedge cclk);
    rstnFull = rf;  cenFull = cf;  cfgFull = df;
    rstnChunk = rc; cenChunk = cc; cfgChunk = dc;
    @(posedge cclk);
    if (!rf)      modelFull = 16'h0;
    else if (cf)  modelFull = df;
    if (!rc)      modelChunk = 16'h0;
    else if (cc)  modelChunk = (modelChunk >> 4) | ({12'h0, dc} << 12);
    @(negedge cclk);
    rstnFull = 1'b1;  cenFull = 1'b0;
    rstnChunk = 1'b1; cenChunk = 1'b0;
  endtask

  // Sweeps every address between clock edges, posting expectations for both instances.
  task automatic checkOutput(input string tag);
    expT e;
    for (int a = 0; a < 16; a++) begin
      addr = a[3:0];
      #1;
      e.tag = tag; e.a = a;
      e.chunked = 1'b0; e.exp = modelFull[a];  sbQ.push_back(e);
      e.chunked = 1'b1; e.exp = modelChunk[a]; sbQ.push_back(e);
      -> sampleEv;
      #1;
    end
  endtask

  initial begin
    rstnFull = 1'b0; cenFull = 1'b0; cfgFull = '0;
    rstnChunk = 1'b0; cenChunk = 1'b0; cfgChunk = '0;
    addr = '0;
    modelFull = 'x; modelChunk = 'x;

    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
    checkOutput("reset");

    applyStimulus(1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 4'hF);
    checkOutput("full_load");

    // Combinational read: addr 0 then 2 with no edge in between.
    @(negedge cclk);
    checkOutput("comb_read");

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'hF);
    checkOutput("hold");

    // A cen pulse that never spans a rising edge must not load.
    @(negedge cclk);
    #10 cenFull = 1'b1; cfgFull = 16'hFFFF; cenChunk = 1'b1; cfgChunk = 4'hF;
    #10 cenFull = 1'b0; cenChunk = 1'b0;
    checkOutput("glitch");

    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 4'hF);
    checkOutput("reset_priority");

    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'h3);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'hC);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'h5);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'hA);
    checkOutput("chunk_load");

    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'h3);
    checkOutput("chunk_extra");

    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'h3);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 4'hC);
    checkOutput("partial_chunks");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 4'h5);
    checkOutput("partial_reset");

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
                    $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 4'($urandom));
      checkOutput("random");
    end

    for (int w = 0; w < 10 && sbQ.size() > 0; w++) #1;
    if (sbQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", sbQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
